// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle between a divider client and seq_divider.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift/subtract divider, one quotient bit per clock, unsigned or
// two's-complement operands, with divide-by-zero and signed-overflow flags.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one trial subtraction per cycle, WIDTH cycles
// FIX   | apply result signs, publish quotient/remainder
// DONE  | done pulse; start here begins the next division
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dmag_q;
    logic [CW-1:0]    cnt;
    logic             neg_quo;
    logic             neg_rem;
    logic             ovf_pend;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             is_zero;
    logic             is_ovf;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] r_sub;
    logic             take;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
        dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag = dvs_neg ? -bus.divisor : bus.divisor;
        is_zero = (bus.divisor == '0);
        is_ovf  = bus.signed_mode
                  && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                  && (bus.divisor == '1);
        // The kept remainder is always below the divisor, so WIDTH bits hold
        // it; only the shifted trial value needs the extra bit.
        r_sh    = {r_q, q_q[WIDTH-1]};
        take    = (r_sh >= {1'b0, dmag_q});
        r_sub   = r_sh[WIDTH-1:0] - dmag_q;
        q_fix   = neg_quo ? -q_q : q_q;
        r_fix   = neg_rem ? -r_q : r_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            cnt             <= '0;
            r_q             <= '0;
            q_q             <= '0;
            dmag_q          <= '0;
            neg_quo         <= 1'b0;
            neg_rem         <= 1'b0;
            ovf_pend        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (is_zero) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.busy        <= 1'b0;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.overflow    <= 1'b0;
                        end else begin
                            state           <= RUN;
                            bus.busy        <= 1'b1;
                            bus.div_by_zero <= 1'b0;
                            bus.overflow    <= 1'b0;
                            ovf_pend        <= is_ovf;
                            neg_quo         <= dvd_neg ^ dvs_neg;
                            neg_rem         <= dvd_neg;
                            q_q             <= dvd_mag;
                            dmag_q          <= dvs_mag;
                            r_q             <= '0;
                            cnt             <= CW'(WIDTH);
                        end
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r_q <= take ? r_sub : r_sh[WIDTH-1:0];
                    q_q <= {q_q[WIDTH-2:0], take};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.quotient  <= q_fix;
                    bus.remainder <= r_fix;
                    bus.overflow  <= ovf_pend;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b1;
                    state         <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: hand vectors, model-checked random
// vectors, back-to-back handshake and reset abort sequences.
module tb_seq_divider;
    localparam int W = 4;

    typedef struct {
        logic         sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        int   sa, sbv, qi, ri;
        v.sm = sm; v.a = a; v.b = b; v.dz = 1'b0; v.ov = 1'b0;
        if (b == 0) begin
            v.q = '1; v.r = a; v.dz = 1'b1;
        end else if (sm) begin
            sa = $signed(a);
            sbv = $signed(b);
            qi = sa / sbv;
            ri = sa % sbv;
            v.q = qi[W-1:0];
            v.r = ri[W-1:0];
            v.ov = (a == 4'b1000) && (b == 4'b1111);
        end else begin
            v.q = a / b;
            v.r = a % b;
        end
        return v;
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the load edge.
    task automatic drive(input vec_t v, input bit push);
        bus.signed_mode = v.sm;
        bus.dividend    = v.a;
        bus.divisor     = v.b;
        bus.start       = 1'b1;
        if (push) sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d edges", edges);
        end
    endtask

    task automatic check_result(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got done with empty queue expected pending entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, " quotient"},    int'(bus.quotient),    int'(e.q));
        chk({tag, " remainder"},   int'(bus.remainder),   int'(e.r));
        chk({tag, " div_by_zero"}, int'(bus.div_by_zero), int'(e.dz));
        chk({tag, " overflow"},    int'(bus.overflow),    int'(e.ov));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int edges, bcyc;
        drive(v, 1'b1);
        wait_done(edges, bcyc);
        chk({tag, " latency"},     edges, v.dz ? 0 : W + 1);
        chk({tag, " busy_cycles"}, bcyc,  v.dz ? 0 : W + 1);
        check_result(tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " done_single"},   int'(bus.done),     0);
        chk({tag, " quotient_hold"}, int'(bus.quotient), int'(v.q));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " busy"},        int'(bus.busy),        0);
        chk({tag, " done"},        int'(bus.done),        0);
        chk({tag, " quotient"},    int'(bus.quotient),    0);
        chk({tag, " remainder"},   int'(bus.remainder),   0);
        chk({tag, " div_by_zero"}, int'(bus.div_by_zero), 0);
        chk({tag, " overflow"},    int'(bus.overflow),    0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[13];
        vec_t va, vb, vj;
        int   edges, bcyc, t0, done_seen;

        tbl[0]  = '{1'b0, 4'd13,    4'd3,    4'd4,    4'd1,    1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1001,  4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0111,  4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'd9,     4'd0,    4'b1111, 4'b1001, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'b1000,  4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 4'd15,    4'd1,    4'd15,   4'd0,    1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'd2,     4'd7,    4'd0,    4'd2,    1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'd6,     4'd4,    4'd1,    4'd2,    1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'b1101,  4'd0,    4'b1111, 4'b1101, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'b1000,  4'b0011, 4'b1110, 4'b1110, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'd15,    4'd15,   4'd1,    4'd0,    1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b1000,  4'b1111, 4'd0,    4'd8,    1'b0, 1'b0};
        tbl[12] = '{1'b1, 4'b1111,  4'b1111, 4'd1,    4'd0,    1'b0, 1'b0};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            run_vec(model(rs, ra, rb), $sformatf("rnd%0d %0d/%0d s%0d", i, ra, rb, rs));
        end

        // back-to-back with a stray start during RUN
        va = '{1'b0, 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0};
        vb = '{1'b0, 4'd2,  4'd7, 4'd0,  4'd2, 1'b0, 1'b0};
        vj = '{1'b1, 4'd9,  4'd3, 4'd0,  4'd0, 1'b0, 1'b0};
        drive(va, 1'b1);
        wait_done(edges, bcyc);
        chk("b2b first latency", edges, W + 1);
        t0 = cyc;
        check_result("b2b first");
        drive(vb, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(vj, 1'b0);
        wait_done(edges, bcyc);
        chk("b2b spacing", cyc - t0, W + 2);
        check_result("b2b second");
        @(posedge clk);
        @(negedge clk);
        chk("b2b stray start busy", int'(bus.busy), 0);
        chk("b2b stray start done", int'(bus.done), 0);

        // reset on the third RUN cycle aborts without a done pulse
        drive('{1'b0, 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0}, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_cleared("midreset");
        rst_n = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        chk("midreset no_done", done_seen, 0);
        run_vec('{1'b0, 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 1'b0}, "post_reset");

        chk("scoreboard empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
